serial_subtractor: RTL
======================

# serial_subtractor

Bit-serial unsigned subtractor computing `a - b` over WIDTH clock cycles, one bit per cycle, LSB first. It reuses the existing single-bit `full_subtractor` cell as its datapath and keeps the borrow in a flip-flop between bits. It sits directly downstream of the full-subtractor cell, accepting parallel operands from a requester via a start/ready handshake and returning a parallel difference plus final borrow.

## Interface
- `WIDTH`, default 8, operand/result width in bits; legal range WIDTH >= 1.
- `clk`  input  1  single clock; all state updates on rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `start`  input  1  request; sampled only when `ready` = 1.
- `a`  input  WIDTH  minuend, captured on the accepting edge.
- `b`  input  WIDTH  subtrahend, captured on the accepting edge.
- `ready`  output  1  high in IDLE; start accepted when `start` & `ready`.
- `busy`  output  1  high in SHIFT.
- `done`  output  1  one-cycle pulse in DONE; result valid.
- `diff`  output  WIDTH  registered result, `(a - b) mod 2^WIDTH`.
- `borrow_out`  output  1  registered final borrow; 1 iff `a < b` unsigned.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: `ready`=1. On edge with `start`=1: load `a_sr`<=a, `b_sr`<=b, `borrow_q`<=0, `cnt`<=0, go SHIFT.
- SHIFT: cell inputs are `a_sr[0]`, `b_sr[0]`, `borrow_q`. Each edge: `a_sr`, `b_sr` shift right; cell diff bit shifts into MSB of `res_sr`; `borrow_q`<=cell borrow; `cnt`++. On edge where `cnt` = WIDTH-1: `diff`<=final `res_sr` including this bit, `borrow_out`<=cell borrow, go DONE.
- DONE: `done`=1 for exactly one cycle, then unconditionally IDLE.
- `start` in SHIFT or DONE is ignored; operand changes after acceptance have no effect.
- `diff`/`borrow_out` hold the last result until the next completion, and are not cleared on a new start.
- `cnt` width is `$clog2(WIDTH+1)`. WIDTH=1: a single SHIFT cycle.
- `ready`, `busy`, `done` are decoded from the state register with no combinational path from `start`.

## Timing
- Reset values: state IDLE, `ready`=1, `busy`=0, `done`=0, `diff`=0, `borrow_out`=0, internal shift registers and `borrow_q` = 0.
- Accepting edge E0. Shift edges E1..E_WIDTH. The result registers update at E_WIDTH. `done` is high from E_WIDTH to E_WIDTH+1. `ready` returns at E_WIDTH+1.
- Throughput: one operation per WIDTH+2 cycles when `start` is held high continuously. `ready` is low for WIDTH+1 cycles between acceptances.
- Reset asserted mid-operation: immediate return to reset values. The operation is aborted, no `done` is produced, and the prior result is cleared.
- Deassertion of reset: the first possible acceptance is on the next rising edge with `start`=1.

## Structure
- Shared package `serial_sub_pkg`: state encoding constants `ST_IDLE`=2'd0, `ST_SHIFT`=2'd1, `ST_DONE`=2'd2.
- One sub-module: the existing `full_subtractor` (ports diff, bo, a, b, bi), instantiated once as the bit cell. Registers, counter and FSM live in `serial_subtractor`.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle -> outputs immediately `ready`=1, `busy`=0, `done`=0, `diff`=0, `borrow_out`=0.
- WIDTH=8, a=100, b=37, start pulse -> `busy` for 8 cycles, `done` pulse 8 edges after acceptance, `diff`=63, `borrow_out`=0.
- a=0x00, b=0x01 -> `diff`=0xFF, `borrow_out`=1. a=0xA5, b=0xA5 -> `diff`=0x00, `borrow_out`=0.
- `start` held high with operands changed every cycle -> only the operands at each accepting edge are used. Acceptances are spaced 10 cycles apart, and `done` occurs exactly once per acceptance.
- Reset at 4th SHIFT cycle of a=0x80, b=0x01 -> no `done`, `diff`=0. A following start with a=3, b=5 -> `diff`=0xFE, `borrow_out`=1.
- WIDTH=3 exhaustive over all 64 operand pairs, plus WIDTH=1 all 4 pairs -> `diff` and `borrow_out` match `{borrow,diff} = a - b` of a (WIDTH+1)-bit model.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor.
//   state_t : FSM state encoding (IDLE / SHIFT / DONE)
package serial_sub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor cell: computes a - b - bi.
//   a, b  : operand bits
//   bi    : borrow in
//   diff  : difference bit
//   bo    : borrow out
module full_subtractor (
    output logic diff,
    output logic bo,
    input  logic a,
    input  logic b,
    input  logic bi
);

    assign diff = a ^ b ^ bi;
    // Borrow when b exceeds a, or when a == b and a borrow is pending.
    assign bo   = (~a & b) | (~(a ^ b) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = (a - b) mod 2^WIDTH, LSB first,
// one bit per clock through a single full_subtractor cell.
//   clk, rst    : clock, asynchronous active-high reset
//   start       : request, accepted when ready
//   a, b        : operands, captured on the accepting edge
//   ready       : idle, can accept
//   busy        : shifting
//   done        : one-cycle pulse, result valid
//   diff        : registered difference (held until next completion)
//   borrow_out  : registered final borrow (a < b)
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state, state_next;
    logic [WIDTH-1:0] a_sr, b_sr, res_sr, res_next;
    logic [CW-1:0]    cnt;
    logic             borrow_q;
    logic             cell_diff, cell_bo;
    logic             last;

    full_subtractor u_cell (
        .diff (cell_diff),
        .bo   (cell_bo),
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bi   (borrow_q)
    );

    // Result register with the current cell bit shifted in at the MSB;
    // after WIDTH shifts the first (LSB) bit has reached position 0.
    generate
        if (WIDTH == 1) begin : g_res_w1
            assign res_next = cell_diff;
        end else begin : g_res_wn
            assign res_next = {cell_diff, res_sr[WIDTH-1:1]};
        end
    endgenerate

    assign last = (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // Handshake outputs decode state only, so start never reaches them.
    always_comb begin
        state_next = state;
        ready      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            ST_IDLE: begin
                ready = 1'b1;
                if (start) state_next = ST_SHIFT;
            end
            ST_SHIFT: begin
                busy = 1'b1;
                if (last) state_next = ST_DONE;
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr       <= '0;
            b_sr       <= '0;
            res_sr     <= '0;
            borrow_q   <= 1'b0;
            cnt        <= '0;
            diff       <= '0;
            borrow_out <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_sr     <= a;
                        b_sr     <= b;
                        borrow_q <= 1'b0;
                        cnt      <= '0;
                    end
                end
                ST_SHIFT: begin
                    a_sr     <= a_sr >> 1;
                    b_sr     <= b_sr >> 1;
                    res_sr   <= res_next;
                    borrow_q <= cell_bo;
                    cnt      <= cnt + CW'(1);
                    if (last) begin
                        diff       <= res_next;
                        borrow_out <= cell_bo;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
